// File: rtl/gate_mac.sv
// gate_mac: signed Q4.4 gated multiply-accumulate.
// Loads a Q4.4 bias into a Q8.8 accumulator and accumulates VEC_LEN x*w
// products. The result is scaled back to Q4.4, saturated, and held on a
// valid/ready output.
// Optional feature macro: GATE_MAC_ROUND_EN selects round-half-up before
// the clamp. When it is undefined, the result is truncated (floor).
module gate_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LEN    = 16,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] bias,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic signed [DATA_WIDTH-1:0] w,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out,
   output logic                         busy
);

   localparam int CNT_W  = $clog2(VEC_LEN + 1);
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN);
   localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 <<< (DATA_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+1)'(1);

   typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

   state_t                       state_q, state_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic signed [PROD_W-1:0]     prod_p0_q, prod_p0_d;
   logic                         vld_p0_q, vld_p0_d;
   logic signed [DATA_WIDTH-1:0] out_q, out_d;
   logic                         out_valid_q, out_valid_d;
   logic                         xfer;

   // Q8.8 -> Q4.4 scaling: floor by default, round half up when enabled.
   // The extra bit keeps the rounding add from wrapping.
   function automatic logic signed [ACC_WIDTH:0] scale_q44(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH:0] ext;
      ext = {a[ACC_WIDTH-1], a};
`ifdef GATE_MAC_ROUND_EN
      return (ext + (ACC_WIDTH+1)'(8)) >>> 4;
`else
      return ext >>> 4;
`endif
   endfunction

   // Clamp a scaled value into the signed DATA_WIDTH range.
   function automatic logic signed [DATA_WIDTH-1:0] sat_q44(input logic signed [ACC_WIDTH:0] r);
      logic signed [ACC_WIDTH:0] c;
      c = r;
      if (r > SAT_MAX) c = SAT_MAX;
      if (r < SAT_MIN) c = SAT_MIN;
      return c[DATA_WIDTH-1:0];
   endfunction

   assign in_ready  = (state_q == ACCUM) && (count_q < LAST_CNT);
   assign xfer      = in_valid && in_ready;
   assign busy      = (state_q != IDLE);
   assign out       = out_q;
   assign out_valid = out_valid_q;

   // Next-state logic.
   // Products are registered one stage before the accumulator; the move to
   // SAT waits for the last product to land, giving two cycles from the
   // final transfer to out_valid.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      prod_p0_d   = prod_p0_q;
      vld_p0_d    = 1'b0;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (vld_p0_q) acc_d = acc_q + ACC_WIDTH'(prod_p0_q);
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = ACC_WIDTH'(bias) <<< 4;
               count_d = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (xfer) begin
               prod_p0_d = x * w;
               vld_p0_d  = 1'b1;
               count_d   = count_q + CNT_W'(1);
            end
            if ((count_q == LAST_CNT) && vld_p0_q) state_d = SAT;
         end
         SAT: begin
            out_d       = sat_q44(scale_q44(acc_q));
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, accumulator and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         vld_p0_q    <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         vld_p0_q    <= vld_p0_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // ---- stage p0: product register (qualified by vld_p0_q) ----
   always_ff @(posedge clk) begin
      prod_p0_q <= prod_p0_d;
   end

endmodule

// File: tb/tb_gate_mac.sv
// Testbench for gate_mac with VEC_LEN=4.
// The driver pushes the expected result of each transaction into a queue.
// A negedge monitor compares the presented output against the head of the
// queue and pops it on handshake.
module tb_gate_mac;
   localparam int DW = 8;
   localparam int VL = 4;
   localparam int AW = 24;

   logic clk = 1'b0;
   logic rst, start, in_valid, in_ready, out_valid, out_ready, busy;
   logic signed [DW-1:0] bias, x, w, out;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];
   int tx_x[VL];
   int tx_w[VL];

   always #5 clk = ~clk;

   gate_mac #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Reference: bias*16 + sum(x*w) in Q8.8, scaled to Q4.4 and clamped.
   function automatic logic [7:0] model(input int b);
      longint s;
      s = longint'(b) * 16;
      for (int i = 0; i < VL; i++) s += longint'(tx_x[i]) * longint'(tx_w[i]);
`ifdef GATE_MAC_ROUND_EN
      s = s + 8;
`endif
      s = s >>> 4;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s[7:0];
   endfunction

   // Monitor: compare presented output with the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h with empty scoreboard", out);
         end else begin
            check("out_value", out, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic fill(input int xv, input int wv);
      for (int i = 0; i < VL; i++) begin
         tx_x[i] = xv;
         tx_w[i] = wv;
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (busy) timeout("wait_idle");
   endtask

   // Issue start, then VL pairs; lit >= 0 is an additional literal expectation.
   task automatic txn(input int b, input int gap, input int rdy_dly, input bit poke, input int lit);
      logic [7:0] e;
      int guard;
      wait_idle();
      bias = 8'(b); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", {7'd0, busy}, 8'd1);
      for (int i = 0; i < VL; i++) begin
         x = 8'(tx_x[i]); w = 8'(tx_w[i]); in_valid = 1'b1;
         guard = 0;
         while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!in_ready) begin
            timeout("in_ready");
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (i < VL - 1) begin
            repeat (gap) begin
               if (poke) start = 1'b1;
               x = 8'($urandom); w = 8'($urandom);
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
      end
      e = model(b);
      exp_q.push_back(e);
      check("in_ready_after_last", {7'd0, in_ready}, 8'd0);
      in_valid = 1'b1; x = 8'sh7F; w = 8'sh7F;
      @(posedge clk); #1;
      check("latency_early", {7'd0, out_valid}, 8'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("latency_two", {7'd0, out_valid}, 8'd1);
      if (lit >= 0) check("spec_value", out, 8'(lit));
      repeat (rdy_dly) begin
         if (poke) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      out_ready = 1'b1;
      if (poke) start = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; start = 1'b0;
      check("valid_cleared", {7'd0, out_valid}, 8'd0);
      check("busy_cleared", {7'd0, busy}, 8'd0);
      check("out_retained", out, e);
      @(posedge clk); #1;
      check("still_idle", {7'd0, busy}, 8'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, {7'd0, busy}, 8'd0);
      check({tag, "_in_ready"}, {7'd0, in_ready}, 8'd0);
      check({tag, "_out_valid"}, {7'd0, out_valid}, 8'd0);
      check({tag, "_out"}, out, 8'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; x = '0; w = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_state("reset");

      // Directed cases.
      fill(8'h10, 8'h08);                txn(0, 0, 0, 1'b0, 8'h20);
      fill(-128, 127);                   txn(0, 1, 2, 1'b0, 8'h80);
      fill(127, 127);                    txn(0, 0, 1, 1'b0, 8'h7F);
      fill(0, 0); tx_x[0] = 1; tx_w[0] = 8;
`ifdef GATE_MAC_ROUND_EN
      txn(0, 0, 0, 1'b0, 8'h01);
`else
      txn(0, 0, 0, 1'b0, 8'h00);
`endif
      tx_w[0] = -8;
`ifdef GATE_MAC_ROUND_EN
      txn(0, 0, 0, 1'b0, 8'h00);
`else
      txn(0, 0, 0, 1'b0, 8'hFF);
`endif
      fill(8'h10, 8'h10);                txn(8'h10, 3, 5, 1'b1, 8'h50);

      // Reset after two transfers in ACCUM.
      bias = 8'h30; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x = 8'h7F; w = 8'h7F; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check_reset_state("rst_accum");
      fill(8'h10, 8'h04);                txn(0, 2, 3, 1'b1, 8'h10);

      // Reset while holding a result in OUT, colliding with handshake and start.
      fill(8'h20, 8'h20);
      bias = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_q.push_back(model(0));
      for (int i = 0; i < VL; i++) begin
         x = 8'(tx_x[i]); w = 8'(tx_w[i]); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("out_before_rst", {7'd0, out_valid}, 8'd1);
      rst = 1'b1; out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b0; start = 1'b0;
      exp_q.delete();
      check_reset_state("rst_out");

      // Randomized transactions.
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < VL; i++) begin
            tx_x[i] = int'($urandom_range(0, 255)) - 128;
            tx_w[i] = int'($urandom_range(0, 255)) - 128;
         end
         txn(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
